// File: rtl/seq_detect_param.sv
// Parametrised serial bit-sequence detector with runtime pattern reload,
// input qualification, overlap mode and a saturating match counter.
//
// Ports:
//   clk       clock, all state on posedge
//   rst       asynchronous active-low reset
//   i         serial data bit (MSB of pattern arrives first)
//   in_valid  qualifies i
//   overlap   1 = overlapping matches, 0 = non-overlapping
//   pat_load  load pat_in as the new pattern (clears history)
//   pat_in    new pattern
//   cnt_clr   synchronous clear of match_cnt
//   out       registered one-cycle match pulse
//   armed     history holds LEN-1 valid bits
//   match_cnt saturating match count
module seq_detect_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
  input  logic             cnt_clr,
  output logic             out,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(LEN);
  localparam logic [FW-1:0] FULL = FW'(LEN - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    ARMED
  } state_t;

  logic [LEN-1:0]   pat_reg, pat_nx;
  logic [LEN-2:0]   hist, hist_nx;
  logic [FW-1:0]    fill, fill_nx;
  logic             out_nx;
  logic [CNT_W-1:0] cnt_nx;

  state_t         state;
  logic           acc;
  logic           hit;
  logic [LEN-1:0] win;

  always_comb begin
    state = FILLING;
    unique case (1'b1)
      (fill == '0):  state = EMPTY;
      (fill == FULL): state = ARMED;
      default:       state = FILLING;
    endcase
  end

  assign armed = (state == ARMED);
  assign acc   = in_valid & ~pat_load;
  // Window = stored history plus the bit arriving this cycle.
  assign win   = {hist, i};
  assign hit   = armed & acc & (win == pat_reg);

  always_comb begin
    pat_nx  = pat_reg;
    hist_nx = hist;
    fill_nx = fill;
    out_nx  = hit;
    cnt_nx  = match_cnt;
    if (pat_load) begin
      pat_nx  = pat_in;
      hist_nx = '0;
      fill_nx = '0;
    end else if (acc) begin
      if (hit && !overlap) begin
        hist_nx = '0;
        fill_nx = '0;
      end else begin
        hist_nx = win[LEN-2:0];
        if (fill != FULL) fill_nx = fill + FW'(1);
      end
    end
    // Clear takes priority over a same-cycle increment.
    if (cnt_clr)
      cnt_nx = '0;
    else if (hit && match_cnt != CMAX)
      cnt_nx = match_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_reg   <= PATTERN;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else begin
      pat_reg   <= pat_nx;
      hist      <= hist_nx;
      fill      <= fill_nx;
      out       <= out_nx;
      match_cnt <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed testbench for seq_detect_param.
// Two instances: default counter width and a 2-bit saturating counter.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       i;
  logic       in_valid;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;

  logic       out, armed;
  logic [7:0] match_cnt;
  logic       out2, armed2;
  logic [1:0] match_cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_detect_param u_dut (
    .clk(clk), .rst(rst), .i(i), .in_valid(in_valid),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .out(out), .armed(armed),
    .match_cnt(match_cnt)
  );

  seq_detect_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .i(i), .in_valid(in_valid),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .out(out2), .armed(armed2),
    .match_cnt(match_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle; inputs change 1 time unit after the edge.
  task automatic cyc(input logic b, input logic v);
    i = b;
    in_valid = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_out", 32'(out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic stream(input string tag, input logic [15:0] bits,
                        input logic [15:0] exp, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      cyc(bits[k], 1'b1);
      chk($sformatf("%s_out%0d", tag, n - k), 32'(out), 32'(exp[k]));
    end
  endtask

  initial begin
    rst = 1'b0; i = 1'b0; in_valid = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
    #2;
    @(posedge clk);
    #1;
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    rst = 1'b1;

    // 1: overlapping, 1011011 -> pulses after bits 4 and 7
    overlap = 1'b1;
    stream("t1", 16'b1011011, 16'b0001001, 7);
    chk("t1_cnt", 32'(match_cnt), 32'd2);
    chk("t1_armed", 32'(armed), 32'd1);

    // 2: non-overlapping, same stream -> one pulse
    do_reset();
    overlap = 1'b0;
    stream("t2a", 16'b1011, 16'b0001, 4);
    chk("t2_armed_after", 32'(armed), 32'd0);
    stream("t2b", 16'b011, 16'b000, 3);
    chk("t2_cnt", 32'(match_cnt), 32'd1);

    // 3: gaps between valid bits; junk on i during gaps
    do_reset();
    overlap = 1'b1;
    cyc(1'b1, 1'b1); chk("t3_v1", 32'(out), 32'd0);
    cyc(1'b1, 1'b0); chk("t3_g1", 32'(out), 32'd0);
    cyc(1'b0, 1'b1); chk("t3_v2", 32'(out), 32'd0);
    cyc(1'b1, 1'b0); chk("t3_g2", 32'(out), 32'd0);
    cyc(1'b1, 1'b1); chk("t3_v3", 32'(out), 32'd0);
    cyc(1'b0, 1'b0); chk("t3_g3", 32'(out), 32'd0);
    cyc(1'b1, 1'b1); chk("t3_v4", 32'(out), 32'd1);
    cyc(1'b0, 1'b0); chk("t3_g4", 32'(out), 32'd0);
    chk("t3_cnt", 32'(match_cnt), 32'd1);

    // 4: reload pattern mid-stream; valid bit with load is ignored
    do_reset();
    stream("t4a", 16'b10, 16'b00, 2);
    pat_in = 4'b0110;
    pat_load = 1'b1;
    cyc(1'b1, 1'b1);
    chk("t4_load_out", 32'(out), 32'd0);
    chk("t4_load_armed", 32'(armed), 32'd0);
    stream("t4b", 16'b0110, 16'b0001, 4);
    chk("t4_cnt", 32'(match_cnt), 32'd1);

    // 5: 7 consecutive overlapping matches, 2-bit counter saturates
    do_reset();
    overlap = 1'b1;
    stream("t5a", 16'b1011, 16'b0001, 4);
    for (int m = 2; m <= 7; m++) begin
      stream("t5b", 16'b011, 16'b001, 3);
      chk($sformatf("t5_cnt2_%0d", m), 32'(match_cnt2),
          (m >= 3) ? 32'd3 : 32'(m));
    end
    chk("t5_cnt8", 32'(match_cnt), 32'd7);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cnt_clr = 1'b1;
    cyc(1'b1, 1'b1);
    chk("t5_clr_out", 32'(out2), 32'd1);
    chk("t5_clr_cnt2", 32'(match_cnt2), 32'd0);
    chk("t5_clr_cnt8", 32'(match_cnt), 32'd0);

    // 6: async reset mid-stream restores PATTERN
    do_reset();
    pat_in = 4'b0110;
    pat_load = 1'b1;
    cyc(1'b0, 1'b0);
    stream("t6a", 16'b101, 16'b000, 3);
    rst = 1'b0;
    #1;
    chk("t6_rst_armed", 32'(armed), 32'd0);
    chk("t6_rst_out", 32'(out), 32'd0);
    #2;
    rst = 1'b1;
    stream("t6b", 16'b11011, 16'b00001, 5);
    chk("t6_cnt", 32'(match_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
